// File: rtl/uart_command_decoder_pkg.sv
// Shared definitions for the UART command decoder: opcodes, parser states and stream modes.
package uart_command_decoder_pkg;

   localparam logic [7:0] CMD_RESET = 8'h72;  // 'r'
   localparam logic [7:0] CMD_GO    = 8'h67;  // 'g'
   localparam logic [7:0] CMD_STOP  = 8'h73;  // 's'
   localparam logic [7:0] CMD_BURST = 8'h6E;  // 'n' followed by count hi, count lo

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StArgHi = 2'd1,
      StArgLo = 2'd2
   } parser_state_t;

   typedef enum logic [1:0] {
      ModeStop  = 2'd0,
      ModeCont  = 2'd1,
      ModeBurst = 2'd2
   } stream_mode_t;

endpackage

// File: rtl/uart_command_decoder_burst_counter.sv
// Loadable down-counter that saturates at zero and pulses when a decrement empties it.
module uart_command_decoder_burst_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_value,
   input  logic             i_dec,
   input  logic             i_clear,
   output logic [WIDTH-1:0] o_remaining,
   output logic             o_zero,
   output logic             o_done_pulse
);

   logic [WIDTH-1:0] r_count;
   logic             r_done;

   // Count register: clear beats load beats decrement; a load never produces a done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (i_clear) begin
            r_count <= '0;
         end else if (i_load) begin
            r_count <= i_value;
         end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
            r_done  <= (r_count == WIDTH'(1));
         end
      end
   end

   assign o_remaining  = r_count;
   assign o_zero       = (r_count == '0);
   assign o_done_pulse = r_done;

endmodule

// File: rtl/uart_command_decoder.sv
// Host command parser: turns received UART bytes into reset / stream-enable / burst control.
module uart_command_decoder
   import uart_command_decoder_pkg::*;
#(
   parameter int unsigned CLOCKFRQ    = 12000000,
   parameter int unsigned ARG_TIMEOUT = 12000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_received,
   input  logic [7:0]  rx_byte,
   input  logic        recv_error,
   input  logic        byte_sent,
   output logic        reset_req,
   output logic        stream_en,
   output logic        burst_done,
   output logic        cmd_error,
   output logic        busy,
   output logic [15:0] remaining
);

   localparam int unsigned TimerW = $clog2(ARG_TIMEOUT + 1);

   if (ARG_TIMEOUT < 1 || CLOCKFRQ == 0) begin : g_bad_param
      $error("uart_command_decoder: ARG_TIMEOUT must be >= 1 and CLOCKFRQ nonzero");
   end

   parser_state_t     r_state, w_state_next;
   stream_mode_t      r_mode, w_mode_next;
   logic [7:0]        r_hi, w_hi_next;
   logic [TimerW-1:0] r_timer, w_timer_next;
   logic              r_reset_req, w_reset_req;
   logic              r_cmd_error, w_cmd_error;
   logic              r_zero_done, w_zero_done;

   logic              w_byte;
   logic              w_cmd_done;
   logic              w_timeout;
   logic              w_load, w_clear, w_dec;
   logic [15:0]       w_value;
   logic [15:0]       w_remaining;
   logic              w_zero;
   logic              w_done_pulse;

   // Parser next-state, mode update and counter control; recv_error discards any same-cycle byte.
   always_comb begin
      w_state_next = r_state;
      w_mode_next  = r_mode;
      w_hi_next    = r_hi;
      w_timer_next = r_timer;
      w_reset_req  = 1'b0;
      w_cmd_error  = 1'b0;
      w_zero_done  = 1'b0;
      w_cmd_done   = 1'b0;
      w_load       = 1'b0;
      w_clear      = 1'b0;
      w_value      = {r_hi, rx_byte};
      w_byte       = rx_received && !recv_error;
      w_timeout    = (r_timer == TimerW'(ARG_TIMEOUT - 1));

      if (recv_error) begin
         w_cmd_error  = 1'b1;
         w_state_next = StIdle;
      end else begin
         case (r_state)
            StIdle: begin
               if (w_byte) begin
                  case (rx_byte)
                     CMD_RESET: begin
                        w_reset_req = 1'b1;
                        w_mode_next = ModeStop;
                        w_clear     = 1'b1;
                        w_cmd_done  = 1'b1;
                     end
                     CMD_GO: begin
                        w_mode_next = ModeCont;
                        w_clear     = 1'b1;
                        w_cmd_done  = 1'b1;
                     end
                     CMD_STOP: begin
                        w_mode_next = ModeStop;
                        w_clear     = 1'b1;
                        w_cmd_done  = 1'b1;
                     end
                     CMD_BURST: begin
                        w_state_next = StArgHi;
                        w_timer_next = '0;
                     end
                     default: w_cmd_error = 1'b1;
                  endcase
               end
            end
            StArgHi: begin
               if (w_byte) begin
                  w_hi_next    = rx_byte;
                  w_state_next = StArgLo;
                  w_timer_next = '0;
               end else if (w_timeout) begin
                  w_state_next = StIdle;
                  w_cmd_error  = 1'b1;
               end else begin
                  w_timer_next = r_timer + TimerW'(1);
               end
            end
            StArgLo: begin
               if (w_byte) begin
                  w_state_next = StIdle;
                  w_cmd_done   = 1'b1;
                  w_load       = 1'b1;
                  if (w_value != 16'd0) begin
                     w_mode_next = ModeBurst;
                  end else begin
                     // Zero-length burst completes immediately.
                     w_mode_next = ModeStop;
                     w_zero_done = 1'b1;
                  end
               end else if (w_timeout) begin
                  w_state_next = StIdle;
                  w_cmd_error  = 1'b1;
               end else begin
                  w_timer_next = r_timer + TimerW'(1);
               end
            end
            default: w_state_next = StIdle;
         endcase
      end

      // A completing command overrides a same-cycle byte_sent.
      w_dec = byte_sent && (r_mode == ModeBurst) && !w_cmd_done && !w_zero;
      if (w_dec && (w_remaining == 16'd1)) begin
         w_mode_next = ModeStop;
      end
   end

   // State and registered pulse outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= StIdle;
         r_mode      <= ModeStop;
         r_hi        <= '0;
         r_timer     <= '0;
         r_reset_req <= 1'b0;
         r_cmd_error <= 1'b0;
         r_zero_done <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_mode      <= w_mode_next;
         r_hi        <= w_hi_next;
         r_timer     <= w_timer_next;
         r_reset_req <= w_reset_req;
         r_cmd_error <= w_cmd_error;
         r_zero_done <= w_zero_done;
      end
   end

   uart_command_decoder_burst_counter #(
      .WIDTH (16)
   ) u_burst_counter (
      .clk          (clk),
      .rst          (rst),
      .i_load       (w_load),
      .i_value      (w_value),
      .i_dec        (w_dec),
      .i_clear      (w_clear),
      .o_remaining  (w_remaining),
      .o_zero       (w_zero),
      .o_done_pulse (w_done_pulse)
   );

   assign reset_req  = r_reset_req;
   assign stream_en  = (r_mode != ModeStop);
   assign burst_done = r_zero_done | w_done_pulse;
   assign cmd_error  = r_cmd_error;
   assign busy       = (r_state != StIdle);
   assign remaining  = w_remaining;

endmodule

// File: tb/tb_uart_command_decoder.sv
// Self-checking bench: directed test-plan steps followed by random traffic against a reference model.
module tb_uart_command_decoder;

   localparam int ArgT = 20;
   localparam int MStop = 0;
   localparam int MCont = 1;
   localparam int MBurst = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx_received = 1'b0;
   logic [7:0]  rx_byte = 8'h00;
   logic        recv_error = 1'b0;
   logic        byte_sent = 1'b0;
   logic        reset_req, stream_en, burst_done, cmd_error, busy;
   logic [15:0] remaining;

   int n_vec = 0;
   int n_fail = 0;

   // Reference model: mode, burst bytes left, argument bytes still expected, idle cycles waited.
   int m_mode = MStop;
   int m_rem = 0;
   int m_args = 0;
   int m_wait = 0;
   int m_hi = 0;
   bit e_reset_req = 0;
   bit e_burst_done = 0;
   bit e_cmd_error = 0;

   uart_command_decoder #(
      .CLOCKFRQ    (12000000),
      .ARG_TIMEOUT (ArgT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_received (rx_received),
      .rx_byte     (rx_byte),
      .recv_error  (recv_error),
      .byte_sent   (byte_sent),
      .reset_req   (reset_req),
      .stream_en   (stream_en),
      .burst_done  (burst_done),
      .cmd_error   (cmd_error),
      .busy        (busy),
      .remaining   (remaining)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_step(input bit r, input bit rx, input logic [7:0] b, input bit err,
                             input bit sent);
      bit cmd_done;
      bit got;
      int n;
      e_reset_req  = 0;
      e_burst_done = 0;
      e_cmd_error  = 0;
      cmd_done     = 0;
      if (r) begin
         m_mode = MStop;
         m_rem  = 0;
         m_args = 0;
         m_wait = 0;
         return;
      end
      got = rx && !err;
      if (err) begin
         e_cmd_error = 1;
         m_args      = 0;
      end else if (m_args == 0) begin
         if (got) begin
            if (b == 8'h72) begin
               e_reset_req = 1;
               m_mode = MStop;
               m_rem = 0;
               cmd_done = 1;
            end else if (b == 8'h67) begin
               m_mode = MCont;
               m_rem = 0;
               cmd_done = 1;
            end else if (b == 8'h73) begin
               m_mode = MStop;
               m_rem = 0;
               cmd_done = 1;
            end else if (b == 8'h6E) begin
               m_args = 2;
               m_wait = 0;
            end else begin
               e_cmd_error = 1;
            end
         end
      end else if (got) begin
         if (m_args == 2) begin
            m_hi   = int'(b);
            m_args = 1;
            m_wait = 0;
         end else begin
            n = m_hi * 256 + int'(b);
            m_args = 0;
            cmd_done = 1;
            if (n > 0) begin
               m_mode = MBurst;
               m_rem  = n;
            end else begin
               m_mode = MStop;
               m_rem  = 0;
               e_burst_done = 1;
            end
         end
      end else begin
         m_wait++;
         if (m_wait >= ArgT) begin
            m_args = 0;
            e_cmd_error = 1;
         end
      end
      if (sent && !cmd_done && m_mode == MBurst && m_rem > 0) begin
         m_rem--;
         if (m_rem == 0) begin
            m_mode = MStop;
            e_burst_done = 1;
         end
      end
   endtask

   // Apply one cycle of inputs, advance the model, then compare every output after the edge.
   task automatic step(input bit r, input bit rx, input logic [7:0] b, input bit err,
                       input bit sent);
      rst         = r;
      rx_received = rx;
      rx_byte     = b;
      recv_error  = err;
      byte_sent   = sent;
      model_step(r, rx, b, err, sent);
      @(posedge clk);
      #1;
      chk("reset_req", 16'(reset_req), 16'(e_reset_req));
      chk("stream_en", 16'(stream_en), 16'(m_mode != MStop));
      chk("burst_done", 16'(burst_done), 16'(e_burst_done));
      chk("cmd_error", 16'(cmd_error), 16'(e_cmd_error));
      chk("busy", 16'(busy), 16'(m_args != 0));
      chk("remaining", remaining, m_rem[15:0]);
   endtask

   task automatic send(input logic [7:0] b);
      step(0, 1, b, 0, 0);
   endtask

   task automatic sent_pulse();
      step(0, 0, 8'h00, 0, 1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0, 0);
   endtask

   logic [7:0] rb;

   initial begin
      // Reset then 'r'
      step(1, 0, 8'h00, 0, 0);
      step(1, 0, 8'h00, 0, 0);
      send(8'h72);
      chk("r_pulse", 16'(reset_req), 16'd1);
      idle(2);

      // 'g', five sent bytes, 's'
      send(8'h67);
      for (int i = 0; i < 5; i++) sent_pulse();
      chk("g_stream", 16'(stream_en), 16'd1);
      send(8'h73);
      chk("s_stream", 16'(stream_en), 16'd0);
      idle(1);

      // Burst of 3, plus an extra byte_sent
      send(8'h6E);
      send(8'h00);
      send(8'h03);
      chk("burst_load", remaining, 16'd3);
      for (int i = 0; i < 4; i++) begin
         sent_pulse();
         idle(1);
      end

      // Zero-length burst; then argument bytes that look like opcodes
      send(8'h6E);
      send(8'h00);
      send(8'h00);
      send(8'h6E);
      send(8'h72);
      send(8'h10);
      chk("raw_arg", remaining, 16'h7210);
      send(8'h73);

      // Timeout in ARG_LO, then 'g' decodes normally
      send(8'h6E);
      send(8'h01);
      idle(ArgT + 2);
      send(8'h67);
      idle(1);

      // Unknown opcode, then burst of 10 interrupted by reset
      send(8'h41);
      send(8'h73);
      send(8'h6E);
      send(8'h00);
      send(8'h0A);
      for (int i = 0; i < 4; i++) sent_pulse();
      step(1, 0, 8'h00, 0, 1);
      chk("rst_rem", remaining, 16'd0);
      idle(1);

      // recv_error in ARG state and together with a byte; command vs byte_sent collision
      send(8'h6E);
      step(0, 1, 8'h00, 1, 0);
      step(0, 1, 8'h67, 1, 0);
      send(8'h6E);
      send(8'h00);
      send(8'h05);
      step(0, 1, 8'h67, 0, 1);
      send(8'h6E);
      step(0, 1, 8'h00, 0, 0);
      step(0, 1, 8'h02, 0, 1);
      step(0, 1, 8'h41, 0, 1);
      idle(2);

      // Random traffic
      for (int it = 0; it < 4000; it++) begin
         case ($urandom_range(0, 9))
            0: rb = 8'h72;
            1: rb = 8'h67;
            2: rb = 8'h73;
            3, 4: rb = 8'h6E;
            5, 6: rb = 8'($urandom_range(0, 2));
            default: rb = 8'($urandom);
         endcase
         step(($urandom_range(0, 599) == 0), ($urandom_range(0, 3) == 0), rb,
              ($urandom_range(0, 49) == 0), ($urandom_range(0, 2) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
